// File: rtl/acct_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : acct_arb_pkg
// Description : Shared types and helpers for the access-controlled peripheral
//               arbiter: FSM state encoding, access-field geometry and the
//               bit-index helper into the access-control vector.
// Optional    : none in this file (ACCT_ARB_VIOLATION_LOG_EN is used by the
//               top level only).
// Revision    : 1.0 - initial release
// ============================================================================
package acct_arb_pkg;

  // Each peripheral owns a 4-bit field, one bit per possible requester.
  localparam int unsigned ACC_BITS_PER_PERIPH = 4;
  localparam int unsigned MAX_MASTERS         = 4;
  localparam int unsigned MID_W               = $clog2(MAX_MASTERS);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_BUSY  = 3'd2,
    ST_RESP  = 3'd3,
    ST_DENY  = 3'd4
  } arb_state_e;

  // Position of master m's permission bit for peripheral p.
  function automatic int unsigned acc_bit_idx(input int unsigned p,
                                              input int unsigned m);
    return p * ACC_BITS_PER_PERIPH + m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/acct_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : acct_rr_pick
// Description : Combinational round-robin pick. Starting at ptr and walking
//               upwards with wrap at NB_MASTERS, returns the first requester.
// Ports       : req   - request vector, one bit per master
//               ptr   - master with highest priority this round
//               valid - at least one request present
//               id    - index of the winning master
// Revision    : 1.0 - initial release
// ============================================================================
module acct_rr_pick
  import acct_arb_pkg::*;
#(
  parameter int unsigned NB_MASTERS = 4
) (
  input  logic [NB_MASTERS-1:0] req,
  input  logic [MID_W-1:0]      ptr,
  output logic                  valid,
  output logic [MID_W-1:0]      id
);

  // Each requester's distance from ptr (mod NB_MASTERS) is computed and the
  // closest one wins; avoids variable-index selects on the request vector.
  int unsigned w_best_d;
  int unsigned w_d;

  always_comb begin
    valid    = 1'b0;
    id       = '0;
    w_best_d = NB_MASTERS;
    w_d      = 0;
    for (int unsigned j = 0; j < NB_MASTERS; j++) begin
      if (j >= int'(ptr)) w_d = j - int'(ptr);
      else                w_d = j + NB_MASTERS - int'(ptr);
      if (req[j] && (w_d < w_best_d)) begin
        w_best_d = w_d;
        valid    = 1'b1;
        id       = MID_W'(j);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/acct_periph_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : acct_periph_arbiter
// Description : Shares one peripheral access port between up to four
//               requesters. Round-robin arbitration, one outstanding access,
//               per-peripheral access check against acc_ctrl_i, local error
//               answer for denied accesses, downstream timeout.
// Ports       : clk_i/rst_ni   - clock, async active-low reset
//               acc_ctrl_i     - permission bits, [4*p+m] allows m on p
//               req_i/pidx_i   - per-master request and target index
//               done_o/err_o   - one-hot completion pulse and error flag
//               slv_*          - downstream request/index/master id/ack
// Optional    : ACCT_ARB_VIOLATION_LOG_EN adds a sticky first-violation log
//               (viol_valid_o, viol_mid_o, viol_pidx_o, viol_timeout_o,
//               viol_clr_i).
// Revision    : 1.0 - initial release
// ============================================================================
module acct_periph_arbiter
  import acct_arb_pkg::*;
#(
  parameter int unsigned NB_MASTERS     = 4,
  parameter int unsigned NB_PERIPHERALS = 9,
  parameter int unsigned PIDX_W         = 4,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [4*NB_PERIPHERALS-1:0]  acc_ctrl_i,
  input  logic [NB_MASTERS-1:0]        req_i,
  input  logic [NB_MASTERS*PIDX_W-1:0] pidx_i,
  output logic [NB_MASTERS-1:0]        done_o,
  output logic                         err_o,
  output logic                         slv_req_o,
  output logic [PIDX_W-1:0]            slv_pidx_o,
  output logic [1:0]                   slv_mid_o,
  input  logic                         slv_ack_i
`ifdef ACCT_ARB_VIOLATION_LOG_EN
  ,
  input  logic                         viol_clr_i,
  output logic                         viol_valid_o,
  output logic [1:0]                   viol_mid_o,
  output logic [PIDX_W-1:0]            viol_pidx_o,
  output logic                         viol_timeout_o
`endif
);

  localparam int unsigned        c_cnt_w    = $clog2(TIMEOUT_CYCLES);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT_CYCLES - 1);

  arb_state_e         r_state;
  arb_state_e         w_next_state;
  logic [MID_W-1:0]   r_mid;
  logic [PIDX_W-1:0]  r_pidx;
  logic [c_cnt_w-1:0] r_cnt;
  logic [MID_W-1:0]   r_rr_ptr;

  logic               w_win_valid;
  logic [MID_W-1:0]   w_win_id;
  logic [PIDX_W-1:0]  w_win_pidx;
  logic               w_allowed;

  acct_rr_pick #(
    .NB_MASTERS (NB_MASTERS)
  ) u_rr_pick (
    .req   (req_i),
    .ptr   (r_rr_ptr),
    .valid (w_win_valid),
    .id    (w_win_id)
  );

  always_comb begin
    w_win_pidx = '0;
    for (int unsigned m = 0; m < NB_MASTERS; m++) begin
      if (w_win_id == MID_W'(m)) w_win_pidx = pidx_i[m*PIDX_W +: PIDX_W];
    end
  end

  // Out-of-range indices match no peripheral and therefore stay denied.
  always_comb begin
    w_allowed = 1'b0;
    for (int unsigned p = 0; p < NB_PERIPHERALS; p++) begin
      for (int unsigned m = 0; m < NB_MASTERS; m++) begin
        if ((r_pidx == PIDX_W'(p)) && (r_mid == MID_W'(m)))
          w_allowed = acc_ctrl_i[acc_bit_idx(p, m)];
      end
    end
  end

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= ST_IDLE;
    else         r_state <= w_next_state;
  end

  // --------------------------------------------------------------- next state
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (w_win_valid) w_next_state = ST_CHECK;
      ST_CHECK: w_next_state = w_allowed ? ST_BUSY : ST_DENY;
      // Ack has priority over the timeout in the limit cycle.
      ST_BUSY: begin
        if (slv_ack_i)                w_next_state = ST_RESP;
        else if (r_cnt == c_cnt_last) w_next_state = ST_DENY;
      end
      ST_RESP:  w_next_state = ST_IDLE;
      ST_DENY:  w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // ------------------------------------------------------------------ outputs
  always_comb begin
    done_o     = '0;
    err_o      = 1'b0;
    slv_req_o  = 1'b0;
    slv_pidx_o = '0;
    slv_mid_o  = '0;
    case (r_state)
      ST_BUSY: begin
        slv_req_o  = 1'b1;
        slv_pidx_o = r_pidx;
        slv_mid_o  = r_mid;
      end
      ST_RESP, ST_DENY: begin
        err_o = (r_state == ST_DENY);
        for (int unsigned m = 0; m < NB_MASTERS; m++) begin
          if (r_mid == MID_W'(m)) done_o[m] = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // ----------------------------------------------------------------- datapath
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_mid    <= '0;
      r_pidx   <= '0;
      r_cnt    <= '0;
      r_rr_ptr <= '0;
    end else begin
      if ((r_state == ST_IDLE) && w_win_valid) begin
        r_mid  <= w_win_id;
        r_pidx <= w_win_pidx;
      end
      // CHECK is the only way into BUSY, so clearing here clears on entry.
      if (r_state == ST_CHECK)     r_cnt <= '0;
      else if (r_state == ST_BUSY) r_cnt <= r_cnt + 1'b1;
      if ((r_state == ST_RESP) || (r_state == ST_DENY))
        r_rr_ptr <= (r_mid == MID_W'(NB_MASTERS - 1)) ? '0 : r_mid + 1'b1;
    end
  end

`ifdef ACCT_ARB_VIOLATION_LOG_EN
  logic              r_viol_valid;
  logic [MID_W-1:0]  r_viol_mid;
  logic [PIDX_W-1:0] r_viol_pidx;
  logic              r_viol_timeout;
  logic              w_enter_deny;

  assign w_enter_deny = (w_next_state == ST_DENY) && (r_state != ST_DENY);

  // A coincident clear re-opens the log, so the new capture wins.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_viol_valid   <= 1'b0;
      r_viol_mid     <= '0;
      r_viol_pidx    <= '0;
      r_viol_timeout <= 1'b0;
    end else if (w_enter_deny && (!r_viol_valid || viol_clr_i)) begin
      r_viol_valid   <= 1'b1;
      r_viol_mid     <= r_mid;
      r_viol_pidx    <= r_pidx;
      r_viol_timeout <= (r_state == ST_BUSY);
    end else if (viol_clr_i) begin
      r_viol_valid   <= 1'b0;
      r_viol_mid     <= '0;
      r_viol_pidx    <= '0;
      r_viol_timeout <= 1'b0;
    end
  end

  assign viol_valid_o   = r_viol_valid;
  assign viol_mid_o     = r_viol_mid;
  assign viol_pidx_o    = r_viol_pidx;
  assign viol_timeout_o = r_viol_timeout;
`endif

endmodule
`default_nettype wire

// File: tb/tb_acct_periph_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_acct_periph_arbiter
// Description : Directed self-checking bench for acct_periph_arbiter
//               (TIMEOUT_CYCLES = 8). Covers the violation log when
//               ACCT_ARB_VIOLATION_LOG_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_acct_periph_arbiter;

  logic        clk;
  logic        rst_n;
  logic [35:0] acc_ctrl;
  logic [3:0]  req;
  logic [15:0] pidx;
  logic [3:0]  done;
  logic        err;
  logic        slv_req;
  logic [3:0]  slv_pidx;
  logic [1:0]  slv_mid;
  logic        slv_ack;
`ifdef ACCT_ARB_VIOLATION_LOG_EN
  logic        viol_clr;
  logic        viol_valid;
  logic [1:0]  viol_mid;
  logic [3:0]  viol_pidx;
  logic        viol_timeout;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  acct_periph_arbiter #(
    .NB_MASTERS     (4),
    .NB_PERIPHERALS (9),
    .PIDX_W         (4),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .acc_ctrl_i     (acc_ctrl),
    .req_i          (req),
    .pidx_i         (pidx),
    .done_o         (done),
    .err_o          (err),
    .slv_req_o      (slv_req),
    .slv_pidx_o     (slv_pidx),
    .slv_mid_o      (slv_mid),
    .slv_ack_i      (slv_ack)
`ifdef ACCT_ARB_VIOLATION_LOG_EN
    ,
    .viol_clr_i     (viol_clr),
    .viol_valid_o   (viol_valid),
    .viol_mid_o     (viol_mid),
    .viol_pidx_o    (viol_pidx),
    .viol_timeout_o (viol_timeout)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed no end expected end of run");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n    = 1'b0;
    acc_ctrl = '0;
    req      = '0;
    pidx     = '0;
    slv_ack  = 1'b0;
`ifdef ACCT_ARB_VIOLATION_LOG_EN
    viol_clr = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("rst_done",     done,     0);
    check("rst_err",      err,      0);
    check("rst_slv_req",  slv_req,  0);
    check("rst_slv_pidx", slv_pidx, 0);
    check("rst_slv_mid",  slv_mid,  0);
`ifdef ACCT_ARB_VIOLATION_LOG_EN
    check("rst_viol_valid", viol_valid, 0);
`endif
    rst_n = 1'b1;
    tick();

    // Round robin: all request, all allowed, ack held high (also outside BUSY)
    acc_ctrl = '1;
    slv_ack  = 1'b1;
    req      = 4'hF;
    for (int k = 0; k < 5; k++) begin
      tick();                                   // CHECK
      tick();                                   // BUSY
      check($sformatf("rr%0d_slv_req", k), slv_req, 1);
      check($sformatf("rr%0d_slv_mid", k), slv_mid, k % 4);
      tick();                                   // RESP
      check($sformatf("rr%0d_done", k), done, 1 << (k % 4));
      check($sformatf("rr%0d_err", k),  err,  0);
      tick();                                   // IDLE
      check($sformatf("rr%0d_done_pulse", k), done, 0);
    end
    req     = '0;
    slv_ack = 1'b0;
    tick();                                     // rr pointer now 1

    // Allowed access, ack one cycle after slv_req
    acc_ctrl    = '0;
    acc_ctrl[9] = 1'b1;
    pidx[7:4]   = 4'd2;
    req         = 4'b0010;
    tick();                                     // CHECK
    check("ok_check_slv_req", slv_req, 0);
    tick();                                     // BUSY
    check("ok_slv_req",  slv_req,  1);
    check("ok_slv_pidx", slv_pidx, 2);
    check("ok_slv_mid",  slv_mid,  1);
    tick();
    check("ok_busy2_slv_req", slv_req, 1);
    check("ok_busy2_done",    done,    0);
    slv_ack = 1'b1;
    tick();                                     // RESP
    check("ok_done",    done,    4'b0010);
    check("ok_err",     err,     0);
    check("ok_req_low", slv_req, 0);
    slv_ack = 1'b0;
    req     = '0;
    tick();
    check("ok_done_clr", done, 0);

    // Same request, permission bit cleared: denied in 3 cycles
    acc_ctrl    = '1;
    acc_ctrl[9] = 1'b0;
    req         = 4'b0010;
    tick();                                     // CHECK
    check("deny_check_slv_req", slv_req, 0);
    check("deny_check_done",    done,    0);
    tick();                                     // DENY
    check("deny_done",    done,    4'b0010);
    check("deny_err",     err,     1);
    check("deny_slv_req", slv_req, 0);
    req = '0;
`ifdef ACCT_ARB_VIOLATION_LOG_EN
    check("log_acc_valid",   viol_valid,   1);
    check("log_acc_mid",     viol_mid,     1);
    check("log_acc_pidx",    viol_pidx,    2);
    check("log_acc_timeout", viol_timeout, 0);
`endif
    tick();
    check("deny_done_clr", done, 0);
    check("deny_err_clr",  err,  0);
`ifdef ACCT_ARB_VIOLATION_LOG_EN
    viol_clr = 1'b1;
    tick();
    viol_clr = 1'b0;
    check("log_clr_valid", viol_valid, 0);
`endif

    // Timeout: master 2, no ack -> 8 BUSY cycles then error
    acc_ctrl   = '1;
    pidx[11:8] = 4'd0;
    req        = 4'b0100;
    tick();                                     // CHECK
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("to_busy%0d_slv_req", i), slv_req, 1);
    end
    tick();                                     // DENY
    check("to_slv_req", slv_req, 0);
    check("to_done",    done,    4'b0100);
    check("to_err",     err,     1);
    req = '0;
`ifdef ACCT_ARB_VIOLATION_LOG_EN
    check("log_to_valid",   viol_valid,   1);
    check("log_to_mid",     viol_mid,     2);
    check("log_to_timeout", viol_timeout, 1);
`endif
    tick();
`ifdef ACCT_ARB_VIOLATION_LOG_EN
    viol_clr = 1'b1;
    tick();
    viol_clr = 1'b0;
`endif

    // Ack in the limit cycle wins; acc_ctrl change and req drop in BUSY
    pidx[15:12] = 4'd1;
    req         = 4'b1000;
    tick();                                     // CHECK
    tick();                                     // BUSY, count 0
    acc_ctrl = '0;
    req      = '0;
    repeat (6) tick();
    tick();                                     // BUSY, count 7
    check("lim_slv_req", slv_req, 1);
    check("lim_slv_mid", slv_mid, 3);
    slv_ack = 1'b1;
    tick();                                     // RESP
    check("lim_done", done, 4'b1000);
    check("lim_err",  err,  0);
`ifdef ACCT_ARB_VIOLATION_LOG_EN
    check("lim_log_valid", viol_valid, 0);
`endif
    slv_ack = 1'b0;
    tick();                                     // rr pointer now 0

    // Out-of-range peripheral index
    acc_ctrl  = '1;
    pidx[3:0] = 4'd9;
    req       = 4'b0001;
    tick();                                     // CHECK
    tick();                                     // DENY
    check("oor_done",    done,    4'b0001);
    check("oor_err",     err,     1);
    check("oor_slv_req", slv_req, 0);
`ifdef ACCT_ARB_VIOLATION_LOG_EN
    check("log_oor_valid",   viol_valid,   1);
    check("log_oor_mid",     viol_mid,     0);
    check("log_oor_pidx",    viol_pidx,    9);
    check("log_oor_timeout", viol_timeout, 0);
`endif
    req       = '0;
    pidx[3:0] = 4'd0;
    tick();                                     // rr pointer now 1

    // Reset asserted during BUSY
    req = 4'b0100;
    tick();                                     // CHECK
    tick();                                     // BUSY
    check("rb_slv_req", slv_req, 1);
    check("rb_slv_mid", slv_mid, 2);
    #3;
    rst_n = 1'b0;
    #1;
    check("rb_async_slv_req", slv_req, 0);
    check("rb_async_done",    done,    0);
    check("rb_async_mid",     slv_mid, 0);
    tick();
    rst_n = 1'b1;
    req   = 4'hF;
    tick();                                     // CHECK
    check("rb_check_slv_req", slv_req, 0);
    tick();                                     // BUSY
    check("rb_restart_mid", slv_mid, 0);
    slv_ack = 1'b1;
    tick();
    check("rb_restart_done", done, 4'b0001);
    req     = '0;
    slv_ack = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/acct_periph_arbiter.md
Name: acct_periph_arbiter

Overview:
- Shares a single peripheral access port between up to four bus requesters.
- Each request is checked against the per-peripheral access-control vector produced by the access-control register block. Granted requests are forwarded downstream; denied requests are answered locally with an error.
- Sits between the requester side and the peripheral crossbar slot.
- Round-robin fairness, one outstanding transaction, and a downstream timeout.

Parameters:
- NB_MASTERS, 4, number of requesters (1..4); requester m maps to bit m of each peripheral's 4-bit access field.
- NB_PERIPHERALS, 9, number of peripherals covered by acc_ctrl_i.
- PIDX_W, 4, width of one peripheral index (must satisfy 2**PIDX_W >= NB_PERIPHERALS).
- TIMEOUT_CYCLES, 256, maximum cycles in BUSY before forced error completion (>= 2).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- acc_ctrl_i  in  4*NB_PERIPHERALS  access vector; bit [4*p+m]=1 allows master m on peripheral p
- req_i  in  NB_MASTERS  request, held high until matching done_o
- pidx_i  in  NB_MASTERS*PIDX_W  target peripheral index per master, slice m at [m*PIDX_W +: PIDX_W]
- done_o  out  NB_MASTERS  one-hot, one-cycle completion pulse
- err_o  out  1  valid with done_o; 1 = denied or timed out
- slv_req_o  out  1  downstream request
- slv_pidx_o  out  PIDX_W  downstream peripheral index
- slv_mid_o  out  2  downstream master id
- slv_ack_i  in  1  downstream completion

Behaviour:
- Reset (async assert, sync release): state IDLE, rr pointer 0, timeout counter 0. All outputs are 0: done_o, err_o, slv_req_o, slv_pidx_o, slv_mid_o.
- FSM states: IDLE, CHECK, BUSY, RESP, DENY.
- IDLE:
  - If any req_i is high, pick the first requesting master starting at the rr pointer, ascending with wrap at NB_MASTERS.
  - Latch the winner id and its pidx_i, then go to CHECK.
- CHECK (1 cycle):
  - acc_ctrl_i is sampled in this cycle only.
  - If latched pidx >= NB_PERIPHERALS, or bit [4*pidx+mid] = 0, go to DENY.
  - Otherwise go to BUSY.
- BUSY:
  - slv_req_o = 1; slv_pidx_o and slv_mid_o are driven from the latches.
  - On slv_ack_i = 1, go to RESP.
  - The counter increments each BUSY cycle. If it reaches TIMEOUT_CYCLES-1 with no ack, go to DENY (timeout).
  - slv_req_o drops in the cycle after ack or timeout.
- RESP: done_o[mid] = 1, err_o = 0, then IDLE.
- DENY: done_o[mid] = 1, err_o = 1, then IDLE. No downstream request is ever issued for a denied access.
- The rr pointer is set to (mid+1) mod NB_MASTERS on leaving RESP or DENY.
- Latency:
  - Allowed access with immediate ack: request to done is 4 cycles (IDLE, CHECK, BUSY, RESP).
  - Denied access: 3 cycles.
- Boundary conditions:
  - Requester drops req_i mid-transaction: the transaction still completes and done_o still pulses.
  - acc_ctrl_i changes during BUSY: no effect on the current transaction.
  - slv_ack_i outside BUSY: ignored.
  - slv_ack_i in the same cycle the counter hits its limit: the ack wins, giving RESP.
  - A master still requesting after done may be re-arbitrated no earlier than the IDLE cycle after done.
- The timeout counter clears on entry to BUSY.
- Masters >= NB_MASTERS never exist. Bits of acc_ctrl_i for unused masters are ignored.

Optional Feature:
- Macro: ACCT_ARB_VIOLATION_LOG_EN.
- Defined:
  - Extra outputs viol_valid_o (1), viol_mid_o (2), viol_pidx_o (PIDX_W), viol_timeout_o (1), plus extra input viol_clr_i (1).
  - The first DENY entry after reset or clear captures mid, pidx, and the cause (timeout=1 / access=0). viol_valid_o becomes sticky 1; later violations do not overwrite.
  - viol_clr_i clears viol_valid_o and the captured fields next cycle. If clear and a new violation coincide, the new capture wins.
- Undefined: none of these ports or registers exist.

Decomposition:
- Package acct_arb_pkg:
  - state enum (IDLE, CHECK, BUSY, RESP, DENY);
  - ACC_BITS_PER_PERIPH = 4;
  - MAX_MASTERS = 4;
  - a function returning bit index 4*p+m.
- Sub-module acct_rr_pick: combinational round-robin pick of the winner from req and pointer, outputting valid and id.

Test Plan:
- acc_ctrl_i bit 4*2+1 = 1; master1 requests pidx=2; slv_ack_i one cycle after slv_req_o -> slv_req_o with pidx 2 and mid 1; done_o=4'b0010, err_o=0.
- Same request with bit 4*2+1 = 0 -> slv_req_o never asserts; done_o=4'b0010 with err_o=1, 3 cycles after request.
- All four masters request continuously, all allowed, immediate acks -> grant order 0,1,2,3,0; each done pulse is exactly one cycle.
- TIMEOUT_CYCLES=8, no ack -> slv_req_o high 8 cycles, then done with err_o=1 (viol_timeout_o=1 when the macro is defined).
- Master0 requests pidx=9 with NB_PERIPHERALS=9 -> denied with err_o=1; log captures mid 0, pidx 9.
- rst_ni asserted during BUSY -> slv_req_o and done_o go 0 immediately; after release, the FSM is in IDLE and arbitration restarts from master 0.
